// File: rtl/an_sec_seq_locator_pkg.sv
// Shared constants, width helpers and FSM state type
// for the AN-code sequential single-error locator.
package an_code_pkg;

  localparam int AN_A    = 4547;
  localparam int AN_CW_W = 29;

  function automatic int rw_of(input int a);
    return $clog2(a);
  endfunction

  function automatic int lw_of(input int cw);
    return $clog2(cw + 1) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

endpackage

// File: rtl/an_sec_seq_locator_if.sv
// Request/result handshake bundle for the locator.
// slave: locator side; master: producer/consumer side.
interface an_sec_seq_locator_if
  import an_code_pkg::*;
#(
  parameter int CW_W = AN_CW_W,
  parameter int R_W  = rw_of(AN_A),
  parameter int L_W  = lw_of(AN_CW_W)
);

  logic            in_valid;
  logic            in_ready;
  logic [R_W-1:0]  s_in;
  logic [CW_W-1:0] cw_in;
  logic            out_valid;
  logic            out_ready;
  logic [L_W-1:0]  loc;
  logic            no_err;
  logic            uncorr;
  logic [CW_W-1:0] cw_out;

  modport slave (
    input  in_valid, s_in, cw_in, out_ready,
    output in_ready, out_valid, loc,
    output no_err, uncorr, cw_out
  );

  modport master (
    output in_valid, s_in, cw_in, out_ready,
    input  in_ready, out_valid, loc,
    input  no_err, uncorr, cw_out
  );

endinterface

// File: rtl/an_sec_seq_locator_pow2_mod_step.sv
// Combinational step p -> 2p mod A for p < A.
// Ports: p (residue in), p2 (doubled residue out).
module an_pow2_mod_step #(
  parameter int A   = 4547,
  parameter int R_W = 13
) (
  input  logic [R_W-1:0] p,
  output logic [R_W-1:0] p2
);

  localparam logic [R_W:0] AV = (R_W + 1)'(A);

  logic [R_W:0] d;
  logic [R_W:0] q;

  // p < A, so 2p < 2A and one subtract is enough
  assign d  = {p, 1'b0};
  assign q  = (d >= AV) ? d - AV : d;
  assign p2 = q[R_W-1:0];

endmodule

// File: rtl/an_sec_seq_locator.sv
// Sequential single-error locator/corrector for AN codes.
// Ports: clk, rst (async high), io (slave handshake bundle).
module an_sec_seq_locator
  import an_code_pkg::*;
#(
  parameter int A    = AN_A,
  parameter int CW_W = AN_CW_W,
  parameter int R_W  = rw_of(A),
  parameter int L_W  = lw_of(CW_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  an_sec_seq_locator_if.slave   io
);

  localparam int K_W = L_W - 1;
  localparam logic [R_W-1:0] AR   = R_W'(A);
  localparam logic [K_W-1:0] KMAX = K_W'(CW_W);
  localparam logic [K_W-1:0] K1   = K_W'(1);

  state_t          state;
  logic [R_W-1:0]  s_q;
  logic [R_W-1:0]  p;
  logic [R_W-1:0]  p2;
  logic [CW_W-1:0] cw_q;
  logic [CW_W-1:0] bit_k;
  logic [K_W-1:0]  k;
  logic [L_W-1:0]  kx;

  an_pow2_mod_step #(
    .A   (A),
    .R_W (R_W)
  ) u_step (
    .p  (p),
    .p2 (p2)
  );

  assign io.in_ready = (state == IDLE) & ~rst;
  assign kx    = {1'b0, k};
  assign bit_k = CW_W'(1) << (k - K1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s_q          <= '0;
      cw_q         <= '0;
      p            <= '0;
      k            <= '0;
      io.out_valid <= 1'b0;
      io.loc       <= '0;
      io.no_err    <= 1'b0;
      io.uncorr    <= 1'b0;
      io.cw_out    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            s_q  <= io.s_in;
            cw_q <= io.cw_in;
            p    <= R_W'(1);
            k    <= K1;
            if (io.s_in == '0) begin
              state        <= DONE;
              io.out_valid <= 1'b1;
              io.loc       <= '0;
              io.no_err    <= 1'b1;
              io.uncorr    <= 1'b0;
              io.cw_out    <= io.cw_in;
            end else if (io.s_in >= AR) begin
              state        <= DONE;
              io.out_valid <= 1'b1;
              io.loc       <= '0;
              io.no_err    <= 1'b0;
              io.uncorr    <= 1'b1;
              io.cw_out    <= io.cw_in;
            end else begin
              state <= SEARCH;
            end
          end
        end
        SEARCH: begin
          if (s_q == p) begin
            state        <= DONE;
            io.out_valid <= 1'b1;
            io.loc       <= kx;
            io.no_err    <= 1'b0;
            io.uncorr    <= 1'b0;
            io.cw_out    <= cw_q - bit_k;
          end else if (s_q == AR - p) begin
            state        <= DONE;
            io.out_valid <= 1'b1;
            io.loc       <= -kx;
            io.no_err    <= 1'b0;
            io.uncorr    <= 1'b0;
            io.cw_out    <= cw_q + bit_k;
          end else if (k == KMAX) begin
            state        <= DONE;
            io.out_valid <= 1'b1;
            io.loc       <= '0;
            io.no_err    <= 1'b0;
            io.uncorr    <= 1'b1;
            io.cw_out    <= cw_q;
          end else begin
            p <= p2;
            k <= k + K1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state        <= IDLE;
            io.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
